// File: rtl/sram_port_arbiter.sv
// ============================================================================
// Module   : sram_port_arbiter
// Purpose  : Shares one asynchronous-SRAM port between fetch (I) and data (D)
//            requesters with multi-cycle access sequencing and bounded priority.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sram_port_arbiter #(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 32,
    parameter int RD_CYCLES  = 2,
    parameter int WR_CYCLES  = 3,
    parameter int MAX_CONSEC = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_resp_valid,
    output logic [DATA_W-1:0] i_resp_rdata,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic              d_req_we,
    input  logic [DATA_W-1:0] d_req_wdata,
    input  logic [3:0]        d_req_wmask,
    output logic              d_resp_valid,
    output logic [DATA_W-1:0] d_resp_rdata,
    output logic [ADDR_W-1:0] io_sram_addr,
    output logic [DATA_W-1:0] io_sram_din,
    output logic              io_sram_en,
    output logic              io_sram_we,
    output logic [3:0]        io_sram_wmask,
    input  logic [DATA_W-1:0] io_sram_dout
);

    localparam int C_CNT_MAX = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);
    localparam int C_STV_W   = $clog2(MAX_CONSEC + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        TURN   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [C_CNT_W-1:0]  r_cnt;
    logic [C_STV_W-1:0]  r_starve;
    logic                r_port_d;
    logic                r_is_wr;
    logic [ADDR_W-1:0]   r_sram_addr;
    logic [DATA_W-1:0]   r_sram_din;
    logic                r_sram_en;
    logic                r_sram_we;
    logic [3:0]          r_sram_wmask;
    logic                r_i_resp_valid;
    logic [DATA_W-1:0]   r_i_resp_rdata;
    logic                r_d_resp_valid;
    logic [DATA_W-1:0]   r_d_resp_rdata;

    logic w_idle;
    logic w_starve_full;
    logic w_grant_d;
    logic w_grant_i;
    logic w_accept;
    logic w_last_rd;
    logic w_last_wr;
    logic w_hold_wr;

    // Fetch wins a contested cycle only once D has used up its consecutive budget.
    assign w_idle        = (r_state == IDLE);
    assign w_starve_full = (r_starve == C_STV_W'(MAX_CONSEC));
    assign w_grant_d     = d_req_valid && !(i_req_valid && w_starve_full);
    assign w_grant_i     = i_req_valid && !w_grant_d;
    assign w_accept      = w_idle && (w_grant_i || w_grant_d);

    assign i_req_ready = w_idle && !reset && w_grant_i;
    assign d_req_ready = w_idle && !reset && w_grant_d;

    assign w_last_rd = (r_state == ACCESS) && !r_is_wr && (r_cnt == C_CNT_W'(RD_CYCLES));
    assign w_last_wr = (r_state == ACCESS) &&  r_is_wr && (r_cnt == C_CNT_W'(WR_CYCLES));
    assign w_hold_wr = (r_state == ACCESS) &&  r_is_wr && (r_cnt == C_CNT_W'(WR_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = ACCESS;
            ACCESS: begin
                if (w_last_rd)      w_next = IDLE;
                else if (w_last_wr) w_next = TURN;
            end
            TURN:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt          <= '0;
            r_starve       <= '0;
            r_port_d       <= 1'b0;
            r_is_wr        <= 1'b0;
            r_sram_addr    <= '0;
            r_sram_din     <= '0;
            r_sram_en      <= 1'b0;
            r_sram_we      <= 1'b0;
            r_sram_wmask   <= '0;
            r_i_resp_valid <= 1'b0;
            r_i_resp_rdata <= '0;
            r_d_resp_valid <= 1'b0;
            r_d_resp_rdata <= '0;
        end else begin
            r_i_resp_valid <= 1'b0;
            r_d_resp_valid <= 1'b0;
            if (w_accept) begin
                r_port_d  <= w_grant_d;
                r_is_wr   <= w_grant_d && d_req_we;
                r_cnt     <= C_CNT_W'(1);
                r_sram_en <= 1'b1;
                r_sram_we <= w_grant_d && d_req_we;
                if (w_grant_d) begin
                    r_sram_addr  <= d_req_addr;
                    r_sram_wmask <= d_req_wmask;
                    r_sram_din   <= d_req_wdata;
                    r_starve     <= i_req_valid ? (r_starve + C_STV_W'(1)) : '0;
                end else begin
                    r_sram_addr  <= i_req_addr;
                    r_sram_wmask <= 4'hF;
                    r_starve     <= '0;
                end
            end
            if (r_state == ACCESS) begin
                r_cnt <= r_cnt + C_CNT_W'(1);
            end
            // Final write cycle drops we but keeps address/data for hold time.
            if (w_hold_wr) begin
                r_sram_we <= 1'b0;
            end
            if (w_last_wr) begin
                r_sram_en      <= 1'b0;
                r_sram_we      <= 1'b0;
                r_d_resp_valid <= 1'b1;
                r_d_resp_rdata <= '0;
            end
            if (w_last_rd) begin
                r_sram_en <= 1'b0;
                if (r_port_d) begin
                    r_d_resp_valid <= 1'b1;
                    r_d_resp_rdata <= io_sram_dout;
                end else begin
                    r_i_resp_valid <= 1'b1;
                    r_i_resp_rdata <= io_sram_dout;
                end
            end
        end
    end

    assign io_sram_addr  = r_sram_addr;
    assign io_sram_din   = r_sram_din;
    assign io_sram_en    = r_sram_en;
    assign io_sram_we    = r_sram_we;
    assign io_sram_wmask = r_sram_wmask;
    assign i_resp_valid  = r_i_resp_valid;
    assign i_resp_rdata  = r_i_resp_rdata;
    assign d_resp_valid  = r_d_resp_valid;
    assign d_resp_rdata  = r_d_resp_rdata;

endmodule

`default_nettype wire
